// File: rtl/booth_pkg.sv
// Shared types and helpers for the run-skipping Booth multiplier.
// States, clog2 and the default extended operand width.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    SHIFT,
    DONE
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int WIDTH_DEF = 8;
  localparam int W1 = WIDTH_DEF + 1;

endpackage

// File: rtl/booth_skip_multiplier_if.sv
// Host-side bundle of the multiplier: start request,
// operands and the busy/done/product/steps results.
interface booth_skip_multiplier_if #(
  parameter int WIDTH = 8
);
  import booth_pkg::*;

  localparam int SW = clog2(WIDTH + 2);

  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  logic [SW-1:0]        steps;

  modport master (
    output start,
    output signed_mode,
    output multiplicand,
    output multiplier,
    input  busy,
    input  done,
    input  product,
    input  steps
  );

  modport slave (
    input  start,
    input  signed_mode,
    input  multiplicand,
    input  multiplier,
    output busy,
    output done,
    output product,
    output steps
  );

endinterface

// File: rtl/booth_run_detect.sv
// Shift size for one SHIFT step: length of the run of equal low
// multiplier bits, clamped by the remaining bit count and MAX_SHIFT.
module booth_run_detect
  import booth_pkg::*;
#(
  parameter int W1L       = 9,
  parameter int MAX_SHIFT = 9,
  parameter int CW        = clog2(W1L + 1)
) (
  input  logic [W1L-1:0] q,
  input  logic [CW-1:0]  rem,
  output logic [CW-1:0]  sh
);

  logic [W1L-1:0] diff;
  logic [CW-1:0]  run;

  always_comb begin
    diff = q ^ (q >> 1);
    // top bit forced so an all-equal word yields a full-width run
    diff[W1L-1] = 1'b1;
    run = CW'(W1L);
    for (int i = W1L - 1; i >= 0; i--) begin
      if (diff[i]) run = CW'(i + 1);
    end
    sh = run;
    if (rem < sh) sh = rem;
    if (CW'(MAX_SHIFT) < sh) sh = CW'(MAX_SHIFT);
  end

endmodule

// File: rtl/booth_skip_multiplier.sv
// Sequential Booth multiplier: one add/sub per EVAL, then a single
// variable-length arithmetic shift across the run of equal bits.
module booth_skip_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_SHIFT = WIDTH + 1
) (
  input  logic clk,
  input  logic rst_n,
  booth_skip_multiplier_if.slave bus
);

  localparam int W1L = WIDTH + 1;
  localparam int CW  = clog2(W1L + 1);

  state_e state_q, state_d;

  logic [W1L-1:0]     a_q, a_d;
  logic [W1L-1:0]     q_q, q_d;
  logic [W1L-1:0]     m_q, m_d;
  logic               qm1_q, qm1_d;
  logic [CW-1:0]      rem_q, rem_d;
  logic [CW-1:0]      steps_q, steps_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [CW-1:0]      sh;
  logic [W1L-1:0]     ext_m, ext_q;
  logic [2*W1L-1:0]   aq_sh;

  booth_run_detect #(
    .W1L       (W1L),
    .MAX_SHIFT (MAX_SHIFT),
    .CW        (CW)
  ) u_run (
    .q   (q_q),
    .rem (rem_q),
    .sh  (sh)
  );

  always_comb begin
    ext_m = {bus.signed_mode & bus.multiplicand[WIDTH-1],
             bus.multiplicand};
    ext_q = {bus.signed_mode & bus.multiplier[WIDTH-1],
             bus.multiplier};
    aq_sh = $signed({a_q, q_q}) >>> sh;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    qm1_d   = qm1_q;
    rem_d   = rem_q;
    steps_d = steps_q;
    prod_d  = prod_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = '0;
          q_d     = ext_q;
          qm1_d   = 1'b0;
          m_d     = ext_m;
          rem_d   = CW'(W1L);
          steps_d = '0;
          state_d = EVAL;
        end
      end
      EVAL: begin
        steps_d = steps_q + 1'b1;
        case ({q_q[0], qm1_q})
          2'b10:   a_d = a_q - m_q;
          2'b01:   a_d = a_q + m_q;
          default: a_d = a_q;
        endcase
        state_d = SHIFT;
      end
      SHIFT: begin
        {a_d, q_d} = aq_sh;
        for (int i = 0; i < W1L; i++) begin
          if (int'(sh) == i + 1) qm1_d = q_q[i];
        end
        rem_d = rem_q - sh;
        if (rem_q == sh) begin
          prod_d  = aq_sh[2*WIDTH-1:0];
          state_d = DONE;
        end else begin
          state_d = EVAL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      qm1_q   <= 1'b0;
      rem_q   <= '0;
      steps_q <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      qm1_q   <= qm1_d;
      rem_q   <= rem_d;
      steps_q <= steps_d;
      prod_q  <= prod_d;
    end
  end

  assign bus.busy    = (state_q == EVAL) || (state_q == SHIFT);
  assign bus.done    = (state_q == DONE);
  assign bus.product = prod_q;
  assign bus.steps   = steps_q;

endmodule

// File: tb/tb_booth_skip_multiplier.sv
// Scoreboard bench: four multiplier instances (8/8-capped/4/16 bit)
// checked against an arithmetic product and run-count model.
module tb_booth_skip_multiplier;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  st = '0;
  logic        sm = 1'b0;
  logic [15:0] opa = '0;
  logic [15:0] opb = '0;

  logic        done_v [4];
  logic        busy_v [4];
  logic [31:0] prod_v [4];
  int          stp_v  [4];

  int wd  [4] = '{8, 8, 4, 16};
  int cap [4] = '{9, 2, 5, 17};

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] p;
    int          s;
  } exp_t;
  exp_t sb[$];

  booth_skip_multiplier_if #(.WIDTH(8))  b8 ();
  booth_skip_multiplier_if #(.WIDTH(8))  b8c ();
  booth_skip_multiplier_if #(.WIDTH(4))  b4 ();
  booth_skip_multiplier_if #(.WIDTH(16)) b16 ();

  assign b8.start         = st[0];
  assign b8.signed_mode   = sm;
  assign b8.multiplicand  = opa[7:0];
  assign b8.multiplier    = opb[7:0];
  assign b8c.start        = st[1];
  assign b8c.signed_mode  = sm;
  assign b8c.multiplicand = opa[7:0];
  assign b8c.multiplier   = opb[7:0];
  assign b4.start         = st[2];
  assign b4.signed_mode   = sm;
  assign b4.multiplicand  = opa[3:0];
  assign b4.multiplier    = opb[3:0];
  assign b16.start        = st[3];
  assign b16.signed_mode  = sm;
  assign b16.multiplicand = opa;
  assign b16.multiplier   = opb;

  always_comb begin
    done_v[0] = b8.done;   busy_v[0] = b8.busy;
    done_v[1] = b8c.done;  busy_v[1] = b8c.busy;
    done_v[2] = b4.done;   busy_v[2] = b4.busy;
    done_v[3] = b16.done;  busy_v[3] = b16.busy;
    prod_v[0] = 32'(b8.product);
    prod_v[1] = 32'(b8c.product);
    prod_v[2] = 32'(b4.product);
    prod_v[3] = 32'(b16.product);
    stp_v[0]  = int'(b8.steps);
    stp_v[1]  = int'(b8c.steps);
    stp_v[2]  = int'(b4.steps);
    stp_v[3]  = int'(b16.steps);
  end

  booth_skip_multiplier #(.WIDTH(8), .MAX_SHIFT(9)) u8 (
    .clk(clk), .rst_n(rst_n), .bus(b8));
  booth_skip_multiplier #(.WIDTH(8), .MAX_SHIFT(2)) u8c (
    .clk(clk), .rst_n(rst_n), .bus(b8c));
  booth_skip_multiplier #(.WIDTH(4), .MAX_SHIFT(5)) u4 (
    .clk(clk), .rst_n(rst_n), .bus(b4));
  booth_skip_multiplier #(.WIDTH(16), .MAX_SHIFT(17)) u16 (
    .clk(clk), .rst_n(rst_n), .bus(b16));

  task automatic chk(string tag, longint got, longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint sx(int w, bit s, logic [15:0] v);
    longint r;
    r = 0;
    for (int i = 0; i < w; i++) if (v[i]) r += (64'sd1 << i);
    if (s && v[w-1]) r -= (64'sd1 << w);
    return r;
  endfunction

  function automatic logic [31:0] ref_prod(int w, bit s,
                                           logic [15:0] a,
                                           logic [15:0] b);
    longint p;
    longint mask;
    p = sx(w, s, a) * sx(w, s, b);
    mask = (64'sd1 <<< (2 * w)) - 1;
    return 32'(p & mask);
  endfunction

  // steps = sum over runs of equal extended-multiplier bits of ceil(len/cap)
  function automatic int ref_steps(int w, int c, bit s,
                                   logic [15:0] b);
    logic [16:0] e;
    int i, j, n;
    e = '0;
    for (int k = 0; k < w; k++) e[k] = b[k];
    e[w] = s & b[w-1];
    i = 0;
    n = 0;
    while (i <= w) begin
      j = i;
      while (j + 1 <= w && e[j+1] == e[i]) j++;
      n += (j - i + 1 + c - 1) / c;
      i = j + 1;
    end
    return n;
  endfunction

  task automatic do_op(int idx, bit s, logic [15:0] a,
                       logic [15:0] b, string tag,
                       bit glitch = 1'b0);
    exp_t e;
    exp_t g;
    int cyc;
    e.p = ref_prod(wd[idx], s, a, b);
    e.s = ref_steps(wd[idx], cap[idx], s, b);
    sb.push_back(e);
    @(negedge clk);
    sm = s; opa = a; opb = b;
    st[idx] = 1'b1;
    @(posedge clk); #1;
    st[idx] = 1'b0;
    cyc = 1;
    while (!done_v[idx] && cyc < 200) begin
      if (glitch && cyc == 1) begin
        sm = ~s; opa = ~a; opb = b ^ 16'h0055;
        st[idx] = 1'b1;
      end
      @(posedge clk); #1;
      st[idx] = 1'b0;
      cyc++;
    end
    cyc--;
    g = sb.pop_front();
    if (!done_v[idx]) chk({tag, "_timeout"}, 0, 1);
    chk({tag, "_prod"}, prod_v[idx], g.p);
    chk({tag, "_steps"}, stp_v[idx], g.s);
    chk({tag, "_lat"}, cyc, 2 * g.s);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy_v[0], 0);
    chk("rst_done", done_v[0], 0);
    chk("rst_prod", prod_v[0], 0);
    chk("rst_steps", stp_v[0], 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(0, 0, 16'h00FF, 16'h00FF, "u255x255");
    chk("u255_val", prod_v[0], 32'hFE01);
    do_op(0, 1, 16'h0080, 16'h0080, "s80x80");
    chk("s80_val", prod_v[0], 32'h4000);
    do_op(0, 1, 16'h0007, 16'h00FD, "s7xm3");
    chk("s7m3_val", prod_v[0], 32'hFFEB);
    do_op(0, 0, 16'h0007, 16'h00FD, "u7x253");
    chk("u7_val", prod_v[0], 32'h06EB);
    do_op(0, 0, 16'h005A, 16'h0000, "zero");
    chk("zero_steps", stp_v[0], 1);
    do_op(1, 0, 16'h005A, 16'h0000, "zero_cap2");
    chk("zcap_steps", stp_v[1], 5);

    repeat (4) @(posedge clk);
    #1;
    chk("done_hold", done_v[1], 1);
    chk("prod_hold", prod_v[1], 0);

    do_op(0, 1, 16'h0012, 16'h00B4, "busy_start", 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_hold_done", done_v[0], 1);

    // abort in SHIFT
    @(negedge clk);
    sm = 0; opa = 16'h00FF; opb = 16'h00FF;
    st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    @(posedge clk); #1;
    chk("in_shift", busy_v[0], 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", busy_v[0], 0);
    chk("abort_done", done_v[0], 0);
    chk("abort_prod", prod_v[0], 0);
    chk("abort_steps", stp_v[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(0, 1, 16'h00C3, 16'h0035, "post_rst");

    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          do_op(2, bit'(s), 16'(a), 16'(b), "w4");

    for (int k = 0; k < 150; k++)
      do_op(3, bit'(k & 1), 16'($urandom), 16'($urandom), "w16");
    do_op(3, 1, 16'h8000, 16'h8000, "w16_min");
    do_op(3, 0, 16'hFFFF, 16'hFFFF, "w16_max");
    do_op(1, 1, 16'h0080, 16'h00AA, "cap2_alt");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
